pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised elastic pipeline register that replaces fixed enable/clear stage registers between IF/ID, ID/EX and the other stages.
- Carries an arbitrary payload under a valid/ready handshake.
- Holds a 2-entry skid (main + skid), so a stage sustains 1 transfer/cycle with fully registered in_ready.
- Supports flush with bubble insertion (NOP) and exposes occupancy for hazard/perf logic.

Parameters:
- DATA_W, 64, payload width; default is {pc[31:0], inst[31:0]}.
- BUBBLE_VALUE, 64'h0000_0000_0000_0013, payload driven when empty, after reset and after flush (pc=0, inst=NOP addi x0,x0,0). Width DATA_W.
- SKID_EN, 1, 1 = two-entry skid buffer. 0 = single entry, with in_ready = !out_valid || out_ready (combinational path, half the area).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  discard all held entries on the next edge; has priority over everything else.
- in_valid  in  1  upstream presents in_data.
- in_ready  out  1  stage accepts in_data this cycle.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream consumes out_data this cycle.
- out_data  out  DATA_W  payload; equals BUBBLE_VALUE whenever out_valid=0.
- occupancy  out  2  number of held entries: 0, 1 or 2 (2 only when SKID_EN=1).

Behaviour:
- Transfers. Accept = in_valid && in_ready. Consume = out_valid && out_ready.
- Reset (rst_n=0, asynchronous):
  - main_valid=0, skid_valid=0.
  - main_data=skid_data=BUBBLE_VALUE.
  - out_valid=0, out_data=BUBBLE_VALUE, occupancy=0, in_ready=1.
  - Reset asserted mid-transfer aborts the transfer; no entry survives.
- States (SKID_EN=1): EMPTY(occ 0), ONE(occ 1, main only), TWO(occ 2, main+skid).
- in_ready = (state != TWO). It is a registered value, with no combinational path from out_ready.
- out_valid = main_valid. out_data = main_data when main_valid, else BUBBLE_VALUE.
- EMPTY:
  - accept -> ONE, main<=in_data.
  - A consume cannot occur in EMPTY.
- ONE:
  - accept && consume -> ONE, main<=in_data.
  - accept && !consume -> TWO, skid<=in_data; main unchanged.
  - !accept && consume -> EMPTY.
  - Otherwise stay in ONE.
- TWO (in_ready=0, so no accept):
  - consume -> ONE, main<=skid, skid<=BUBBLE_VALUE.
  - Otherwise hold both entries.
- Ordering: strict FIFO. Output order equals acceptance order, with no loss and no duplication.
- Latency: 1 cycle from accept to out_valid when starting EMPTY.
- Throughput: 1 transfer/cycle while out_ready=1.
- Flush:
  - Next state is EMPTY. main/skid data <= BUBBLE_VALUE.
  - An accept in the flush cycle is dropped, even though in_ready may be 1 in that cycle.
  - A consume in the flush cycle still counts downstream; the stage does not retract it.
  - flush held for several cycles keeps the stage EMPTY while in_ready stays 1 and all input is discarded.
- SKID_EN=0:
  - States EMPTY/ONE only; the TWO transition never occurs.
  - in_ready = !main_valid || out_ready (combinational).
  - occupancy never exceeds 1.
- Stall: an upstream stall is in_valid=0. A downstream stall is out_ready=0; the stage then fills to TWO and deasserts in_ready, so the stall propagates with one cycle of slack.
- Data integrity: held payloads are stable while out_ready=0 (AXI-style rule). out_data must not change while out_valid=1 and out_ready=0.

Decomposition:
- Package pipe_pkg holds:
  - NOP_INST = 32'h0000_0013.
  - Typedef if_id_payload_t (packed struct {pc[31:0], inst[31:0]}).
  - Enum stage_state_e {ST_EMPTY, ST_ONE, ST_TWO}.
  - Helper constant IF_ID_BUBBLE built from NOP_INST.
- Single module; no sub-module is needed. Each stage instantiates pipe_stage_skid with its payload struct width.

Test Plan:
- Reset: rst_n=0 asynchronously while in_valid=1, in_data=64'h1000_0000_0000_00B3 -> immediately out_valid=0, out_data=64'h13, occupancy=0, in_ready=1.
- Streaming: out_ready=1, push 0x0000_0004_0000_0093, 0x0000_0008_0000_0113, 0x0000_000C_0000_0193 on consecutive cycles -> same three values appear on out_data on consecutive cycles, each one cycle after its accept; in_ready stays 1.
- Back-pressure: push A=0x04/0x93, B=0x08/0x113, with out_ready=0 -> occupancy=2, in_ready=0 the cycle after B is accepted; C held upstream, A held stable on out_data. Release out_ready -> A, B, C exit in order.
- Flush from TWO: with A, B held, flush=1 and in_valid=1, C=0x0C/0x193 -> next cycle occupancy=0, out_valid=0, out_data=0x13; C never appears.
- Simultaneous flush and consume: state ONE with out_ready=1, flush=1 -> A is counted as delivered once, state becomes EMPTY, no duplicate of A.
- SKID_EN=0 build: out_ready=0 with one entry -> in_ready=0 the same cycle; occupancy never exceeds 1; toggling out_ready=1 gives accept+consume in one cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: payload layout, bubble constant and the
// three-state occupancy encoding used by pipe_stage_skid.
package pipe_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_payload_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } stage_state_e;

  // pc=0 carrying addi x0,x0,0 so a bubble decodes as a harmless NOP
  localparam if_id_payload_t IF_ID_BUBBLE = '{pc: 32'h0, inst: NOP_INST};

  function automatic logic [1:0] occ_of(stage_state_e s);
    case (s)
      ST_ONE:  return 2'd1;
      ST_TWO:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register with optional two-entry skid buffer, flush
// with bubble insertion and occupancy reporting.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                 DATA_W       = 64,
  parameter logic [DATA_W-1:0]  BUBBLE_VALUE = DATA_W'(IF_ID_BUBBLE),
  parameter bit                 SKID_EN      = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  stage_state_e      state_reg, state_next;
  logic [DATA_W-1:0] main_data_reg, main_data_next;
  logic [DATA_W-1:0] skid_data_reg, skid_data_next;
  logic              main_valid;
  logic              accept;
  logic              consume;

  assign main_valid = (state_reg != ST_EMPTY);
  assign accept     = in_valid && in_ready;
  assign consume    = main_valid && out_ready;

  assign out_valid  = main_valid;
  assign out_data   = main_valid ? main_data_reg : BUBBLE_VALUE;
  assign occupancy  = occ_of(state_reg);

  always_comb begin
    state_next     = state_reg;
    main_data_next = main_data_reg;
    skid_data_next = skid_data_reg;
    if (flush) begin
      // a concurrent accept is dropped; a concurrent consume is not retracted
      state_next     = ST_EMPTY;
      main_data_next = BUBBLE_VALUE;
      skid_data_next = BUBBLE_VALUE;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            state_next     = ST_ONE;
            main_data_next = in_data;
          end
        end
        ST_ONE: begin
          if (accept && consume) begin
            main_data_next = in_data;
          end else if (accept && SKID_EN) begin
            state_next     = ST_TWO;
            skid_data_next = in_data;
          end else if (consume) begin
            state_next     = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (consume) begin
            state_next     = ST_ONE;
            main_data_next = skid_data_reg;
            skid_data_next = BUBBLE_VALUE;
          end
        end
        default: begin
          state_next = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_EMPTY;
      main_data_reg <= BUBBLE_VALUE;
      skid_data_reg <= BUBBLE_VALUE;
    end else begin
      state_reg     <= state_next;
      main_data_reg <= main_data_next;
      skid_data_reg <= skid_data_next;
    end
  end

  generate
    if (SKID_EN) begin : g_skid
      // registered ready: looks ahead at the next state so no path from out_ready
      logic in_ready_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) in_ready_reg <= 1'b1;
        else        in_ready_reg <= (state_next != ST_TWO);
      end
      assign in_ready = in_ready_reg;
    end else begin : g_single
      assign in_ready = !main_valid || out_ready;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench for pipe_stage_skid: skid build and single-entry build
// side by side, with hand-computed expectations.
module tb_pipe_stage_skid;

  localparam logic [63:0] BUB = 64'h0000_0000_0000_0013;
  localparam logic [63:0] VR  = 64'h1000_0000_0000_00B3;
  localparam logic [63:0] VA  = 64'h0000_0004_0000_0093;
  localparam logic [63:0] VB  = 64'h0000_0008_0000_0113;
  localparam logic [63:0] VC  = 64'h0000_000C_0000_0193;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_data, out_data;
  logic [1:0]  occupancy;

  logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [63:0] b_in_data, b_out_data;
  logic [1:0]  b_occupancy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(64), .BUBBLE_VALUE(BUB), .SKID_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_stage_skid #(.DATA_W(64), .BUBBLE_VALUE(BUB), .SKID_EN(1'b0)) dut_single (
    .clk(clk), .rst_n(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occupancy)
  );

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%016h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic v, input logic [63:0] d,
                             input logic [1:0] occ, input logic rdy);
    check_vec({tag, ".out_valid"}, 64'(v),   64'(out_valid));
    check_vec({tag, ".out_data"},  out_data, d);
    check_vec({tag, ".occupancy"}, 64'(occupancy), 64'(occ));
    check_vec({tag, ".in_ready"},  64'(in_ready),  64'(rdy));
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    // asynchronous reset while an entry is held and input is offered
    in_valid = 1'b1; in_data = VR;
    tick();
    check_vec("pre_rst.occupancy", 64'(occupancy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check_state("rst", 1'b0, BUB, 2'd0, 1'b1);
    check_vec("rst.single_out_data", b_out_data, BUB);
    tick();
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check_state("post_rst", 1'b0, BUB, 2'd0, 1'b1);

    // streaming at one transfer per cycle
    out_ready = 1'b1; in_valid = 1'b1;
    in_data = VA; tick(); check_state("stream_a", 1'b1, VA, 2'd1, 1'b1);
    in_data = VB; tick(); check_state("stream_b", 1'b1, VB, 2'd1, 1'b1);
    in_data = VC; tick(); check_state("stream_c", 1'b1, VC, 2'd1, 1'b1);
    in_valid = 1'b0; tick(); check_state("stream_end", 1'b0, BUB, 2'd0, 1'b1);

    // back-pressure fills the skid, then drains in order
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = VA; tick(); check_state("bp_a", 1'b1, VA, 2'd1, 1'b1);
    in_data = VB; tick(); check_state("bp_b", 1'b1, VA, 2'd2, 1'b0);
    in_data = VC; tick(); check_state("bp_hold", 1'b1, VA, 2'd2, 1'b0);
    out_ready = 1'b1;
    tick(); check_state("drain_b", 1'b1, VB, 2'd1, 1'b1);
    tick(); check_state("drain_c", 1'b1, VC, 2'd1, 1'b1);
    in_valid = 1'b0;
    tick(); check_state("drain_end", 1'b0, BUB, 2'd0, 1'b1);

    // flush from TWO drops the concurrent input
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = VA; tick();
    in_data = VB; tick();
    check_vec("fl2.pre_occupancy", 64'(occupancy), 64'd2);
    flush = 1'b1; in_data = VC;
    tick(); check_state("flush_two", 1'b0, BUB, 2'd0, 1'b1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); check_state("flush_no_c", 1'b0, BUB, 2'd0, 1'b1);

    // flush concurrent with consume delivers A exactly once
    out_ready = 1'b0; in_valid = 1'b1; in_data = VA;
    tick();
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
    #1;
    check_vec("fc.consume_valid", 64'(out_valid), 64'd1);
    check_vec("fc.consume_data",  out_data, VA);
    tick(); check_state("fc_after", 1'b0, BUB, 2'd0, 1'b1);
    // held flush discards input and keeps the stage empty
    in_valid = 1'b1; in_data = VB;
    tick(); check_state("flush_held", 1'b0, BUB, 2'd0, 1'b1);
    flush = 1'b0; in_valid = 1'b0;
    tick(); check_state("fc_no_dup", 1'b0, BUB, 2'd0, 1'b1);

    // single-entry build: combinational ready, occupancy capped at 1
    b_out_ready = 1'b0; b_in_valid = 1'b1; b_in_data = VA;
    #1;
    check_vec("single.ready_empty", 64'(b_in_ready), 64'd1);
    tick();
    check_vec("single.ready_full",  64'(b_in_ready), 64'd0);
    check_vec("single.occ_a",       64'(b_occupancy), 64'd1);
    b_in_data = VB;
    tick();
    check_vec("single.occ_stall",   64'(b_occupancy), 64'd1);
    check_vec("single.data_stall",  b_out_data, VA);
    b_out_ready = 1'b1;
    #1;
    check_vec("single.ready_comb",  64'(b_in_ready), 64'd1);
    tick();
    check_vec("single.data_b",      b_out_data, VB);
    check_vec("single.occ_b",       64'(b_occupancy), 64'd1);
    b_in_valid = 1'b0;
    tick();
    check_vec("single.valid_end",   64'(b_out_valid), 64'd0);
    check_vec("single.occ_end",     64'(b_occupancy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
